// File: rtl/fuzzy_result_collector.sv
// Serial-to-parallel collector for the fuzzifier's result digits (MSB first) with a hold/handshake stage.
// Optional running-maximum tracker enabled by defining FUZZY_COLLECTOR_MAX_TRACK_EN.
module fuzzy_result_collector #(
  parameter int RESULT_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic                    io_inResultValid,
  input  logic                    io_inResult,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [RESULT_WIDTH-1:0] io_out_bits,
  output logic                    io_busy,
  output logic                    io_overrun,
  output logic [RESULT_WIDTH-1:0] io_maxResult
);

  localparam int CW = $clog2(RESULT_WIDTH);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [RESULT_WIDTH-1:0] r_shift;
  logic                    r_out_valid;
  logic [RESULT_WIDTH-1:0] r_out_bits;
  logic                    r_busy;
  logic                    r_overrun;

  logic [1:0]              w_state_next;
  logic                    w_hs;
  logic                    w_start_acc;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_ov_set;
  logic [RESULT_WIDTH-1:0] w_shift_next;

  assign w_hs         = (r_state == S_HOLD) & r_out_valid & io_out_ready;
  assign w_start_acc  = io_start & ((r_state != S_HOLD) | w_hs);
  assign w_accept     = (r_state == S_COLLECT) & ~io_start & io_inResultValid;
  assign w_last       = w_accept & (r_cnt == CW'(RESULT_WIDTH - 1));
  assign w_shift_next = {r_shift[RESULT_WIDTH-2:0], io_inResult};
  // Dropped digit outside COLLECT, or a start that arrives while a result is still unclaimed.
  assign w_ov_set     = (io_inResultValid & (r_state != S_COLLECT)) |
                        ((r_state == S_HOLD) & io_start & ~w_hs);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (io_start) w_state_next = S_COLLECT;
      S_COLLECT: if (w_last) w_state_next = S_HOLD;
      S_HOLD:    if (w_hs) w_state_next = io_start ? S_COLLECT : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_COLLECT);

      if (w_start_acc) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_accept) begin
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        r_shift <= w_last ? '0 : w_shift_next;
      end

      if (w_last) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= w_shift_next;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end

      if (w_ov_set)
        r_overrun <= 1'b1;
      else if (w_start_acc)
        r_overrun <= 1'b0;
    end
  end

  assign io_out_valid = r_out_valid;
  assign io_out_bits  = r_out_bits;
  assign io_busy      = r_busy;
  assign io_overrun   = r_overrun;

`ifdef FUZZY_COLLECTOR_MAX_TRACK_EN
  logic [RESULT_WIDTH-1:0] r_max;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_max <= '0;
    else if (w_hs && (r_out_bits > r_max))
      r_max <= r_out_bits;
  end

  assign io_maxResult = r_max;
`else
  assign io_maxResult = '0;
`endif

endmodule

// File: tb/tb_fuzzy_result_collector.sv
// Self-checking bench: directed frames plus random traffic against a queue-based reference model.
module tb_fuzzy_result_collector;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_start = 1'b0;
  logic         io_inResultValid = 1'b0;
  logic         io_inResult = 1'b0;
  logic         io_out_ready = 1'b0;
  logic         io_out_valid;
  logic [W-1:0] io_out_bits;
  logic         io_busy;
  logic         io_overrun;
  logic [W-1:0] io_maxResult;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: abstract mode plus a queue of collected digits.
  int           m_mode;   // 0 idle, 1 collecting, 2 holding a result
  bit           m_q[$];
  logic         m_valid;
  logic [W-1:0] m_bits;
  logic         m_ov;
  logic [W-1:0] m_max;

  fuzzy_result_collector #(.RESULT_WIDTH(W)) dut (
    .clock           (clock),
    .reset           (reset),
    .io_start        (io_start),
    .io_inResultValid(io_inResultValid),
    .io_inResult     (io_inResult),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_bits     (io_out_bits),
    .io_busy         (io_busy),
    .io_overrun      (io_overrun),
    .io_maxResult    (io_maxResult)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_valid = 1'b0;
    m_bits = '0;
    m_ov = 1'b0;
    m_max = '0;
  endtask

  task automatic model_step(input bit st, input bit vl, input bit d, input bit rdy);
    bit hs, set, clr;
    logic [W-1:0] word;
    hs  = (m_mode == 2) && rdy;
    set = (vl && m_mode != 1) || (m_mode == 2 && st && !hs);
    clr = st && (m_mode != 2 || hs);
    case (m_mode)
      0: if (st) begin m_mode = 1; m_q.delete(); end
      1: begin
        if (st) m_q.delete();
        else if (vl) begin
          m_q.push_back(d);
          if (m_q.size() == W) begin
            word = '0;
            foreach (m_q[i]) word = {word[W-2:0], m_q[i]};
            m_bits = word;
            m_valid = 1'b1;
            m_mode = 2;
            m_q.delete();
          end
        end
      end
      default: if (hs) begin
        m_valid = 1'b0;
`ifdef FUZZY_COLLECTOR_MAX_TRACK_EN
        if (m_bits > m_max) m_max = m_bits;
`endif
        m_mode = st ? 1 : 0;
      end
    endcase
    if (set) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 16'(io_out_valid), 16'(m_valid));
    chk({tag, ".bits"},  16'(io_out_bits),  16'(m_bits));
    chk({tag, ".busy"},  16'(io_busy),      16'(m_mode == 1));
    chk({tag, ".ovr"},   16'(io_overrun),   16'(m_ov));
    chk({tag, ".max"},   16'(io_maxResult), 16'(m_max));
  endtask

  // One clock: inputs applied now, sampled at the next rising edge, outputs checked 1 time unit later.
  task automatic step(input string tag, input bit st, input bit vl, input bit d, input bit rdy);
    io_start = st;
    io_inResultValid = vl;
    io_inResult = d;
    io_out_ready = rdy;
    @(posedge clock);
    model_step(st, vl, d, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic digits(input string tag, input logic [W-1:0] word, input bit gaps, input bit rdy);
    for (int i = W - 1; i >= 0; i--) begin
      step(tag, 1'b0, 1'b1, word[i], rdy);
      if (gaps) step(tag, 1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  task automatic frame(input string tag, input logic [W-1:0] word, input bit gaps, input int wait_n);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    digits(tag, word, gaps, 1'b0);
    for (int i = 0; i < wait_n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before any edge.
  task automatic reset_pulse(input string tag);
    #1 reset = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_valid"}, 16'(io_out_valid), 16'h0);
    chk({tag, ".rst_bits"},  16'(io_out_bits),  16'h0);
    chk({tag, ".rst_busy"},  16'(io_busy),      16'h0);
    chk({tag, ".rst_ovr"},   16'(io_overrun),   16'h0);
    chk({tag, ".rst_max"},   16'(io_maxResult), 16'h0);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_max;
    model_reset();
    #2;
    chk("por.valid", 16'(io_out_valid), 16'h0);
    chk("por.bits",  16'(io_out_bits),  16'h0);
    chk("por.busy",  16'(io_busy),      16'h0);
    chk("por.ovr",   16'(io_overrun),   16'h0);
    @(posedge clock);
    #2 reset = 1'b1;

    // Back-to-back digits, consumer always ready: one-cycle valid pulse.
    step("f1", 1'b1, 1'b0, 1'b0, 1'b1);
    digits("f1", 10'h2CB, 1'b0, 1'b1);
    chk("f1.word", 16'(io_out_bits), 16'h2CB);
    chk("f1.vhi",  16'(io_out_valid), 16'h1);
    step("f1.hs", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("f1.vlo", 16'(io_out_valid), 16'h0);

    // Gapped digits, consumer stalls 5 cycles.
    frame("f2", 10'h2CB, 1'b1, 5);
    chk("f2.word", 16'(io_out_bits), 16'h2CB);

    // Abort after 4 digits, restart with all ones.
    step("ab", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("ab", 1'b0, 1'b1, 1'b1, 1'b0);
    step("ab.restart", 1'b1, 1'b1, 1'b1, 1'b0);
    digits("ab", 10'h3FF, 1'b0, 1'b0);
    chk("ab.word", 16'(io_out_bits), 16'h3FF);
    chk("ab.ovr",  16'(io_overrun),  16'h0);
    step("ab.hs", 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: digit in IDLE, cleared by start; start in HOLD without handshake.
    step("ov.idle", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ov.set", 16'(io_overrun), 16'h1);
    step("ov.start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ov.clr", 16'(io_overrun), 16'h0);
    digits("ov", 10'h155, 1'b0, 1'b0);
    step("ov.hold", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ov.hold_set", 16'(io_overrun), 16'h1);
    chk("ov.hold_bits", 16'(io_out_bits), 16'h155);
    chk("ov.hold_valid", 16'(io_out_valid), 16'h1);
    step("ov.hs", 1'b0, 1'b0, 1'b0, 1'b1);

    // Running maximum over three frames.
    reset_pulse("mx");
    frame("mx1", 10'h100, 1'b0, 0);
    frame("mx2", 10'h2CB, 1'b0, 0);
    frame("mx3", 10'h050, 1'b0, 0);
`ifdef FUZZY_COLLECTOR_MAX_TRACK_EN
    exp_max = 10'h2CB;
`else
    exp_max = 10'h000;
`endif
    chk("mx.final", 16'(io_maxResult), 16'(exp_max));

    // Reset mid-collect after 6 digits, then a clean frame.
    step("mr", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("mr", 1'b0, 1'b1, 1'(i & 1), 1'b0);
    reset_pulse("mr");
    step("mr.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    frame("mr.frame", 10'h2CB, 1'b0, 2);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      step("rnd", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzzy_result_collector.md
FUZZY_RESULT_COLLECTOR -- requirements
Module: fuzzy_result_collector

Interface
REQ-001 Parameter: RESULT_WIDTH, default 10, number of serial result digits gathered per frame (range 2..16).
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 io_start  input  1  frame start; the same pulse that launches the upstream fuzzification stage.
REQ-005 io_inResultValid  input  1  upstream result digit valid this cycle.
REQ-006 io_inResult  input  1  upstream result digit, MSB first.
REQ-007 io_out_valid  output  1  parallel result available.
REQ-008 io_out_ready  input  1  consumer accepts the result.
REQ-009 io_out_bits  output  RESULT_WIDTH  assembled parallel result.
REQ-010 io_busy  output  1  high in COLLECT.
REQ-011 io_overrun  output  1  sticky flag for a dropped digit or dropped start.
REQ-012 io_maxResult  output  RESULT_WIDTH  running maximum of accepted results (see Configuration).

Function
REQ-013 FSM states and transitions:
- IDLE: io_start -> COLLECT.
- COLLECT: final digit accepted -> HOLD.
- HOLD: io_out_valid & io_out_ready -> IDLE, or -> COLLECT if io_start is high in the same cycle.
REQ-014 On entry to COLLECT, digit counter and shift register SHALL be 0.
REQ-015 In COLLECT, each cycle with io_inResultValid SHALL shift the register left, insert io_inResult at the LSB, and increment the counter.
- Cycles without io_inResultValid hold all state.
REQ-016 The RESULT_WIDTH-th accepted digit (counter == RESULT_WIDTH-1) SHALL complete the frame.
- io_out_valid goes high the next cycle (one-cycle registered latency).
- io_out_bits holds the assembled word, first digit at MSB.
REQ-017 io_out_valid and io_out_bits SHALL remain stable in HOLD until handshake.
- Handshake = io_out_valid & io_out_ready.
- io_out_valid drops the cycle after handshake.
REQ-018 io_start during COLLECT SHALL abort the frame: counter and register clear, state stays COLLECT, no flag set.
REQ-019 io_start and a valid digit in the same COLLECT cycle: start wins and the digit is discarded.
REQ-020 Any io_inResultValid in IDLE or HOLD SHALL set io_overrun; the digit is dropped.
REQ-021 io_start in HOLD without a same-cycle handshake SHALL be ignored and SHALL set io_overrun.
REQ-022 io_overrun SHALL clear only when io_start is accepted (IDLE, COLLECT, or HOLD with handshake).
- A same-cycle set condition takes priority over the clear.
REQ-023 io_busy SHALL be a registered decode of state == COLLECT.
REQ-024 io_out_ready SHALL be ignored outside HOLD.

Reset
REQ-025 Asserting reset (low) SHALL immediately, without a clock edge, set:
- state = IDLE
- counter = 0, shift register = 0
- io_out_valid = 0, io_out_bits = 0, io_busy = 0, io_overrun = 0, io_maxResult = 0
REQ-026 Reset asserted mid-COLLECT or mid-HOLD SHALL discard the frame; after deassertion the block waits for a fresh io_start.
REQ-027 Reset deassertion SHALL be synchronised externally; the block does not synchronise it.

Configuration
REQ-028 Macro FUZZY_COLLECTOR_MAX_TRACK_EN.
- Defined: on each handshake, io_maxResult <= max(io_maxResult, io_out_bits), unsigned compare, registered; cleared only by reset.
- Undefined: no comparator or register is built; io_maxResult is tied to 0.

Verification
REQ-029 Reset, io_start, then digits 1,0,1,1,0,0,1,0,1,1 on consecutive valid cycles, io_out_ready=1 -> io_out_valid high for one cycle after the 10th digit, io_out_bits=10'h2CB, then IDLE.
REQ-030 Same frame with valid gaps every other cycle and io_out_ready=0 for 5 cycles -> io_out_bits=10'h2CB held stable, io_out_valid high 5 cycles, handshake on cycle 6.
REQ-031 io_start after 4 digits, then 10 digits of all ones -> io_out_bits=10'h3FF, io_overrun=0.
REQ-032 Digit valid in IDLE, then io_start -> io_overrun 1 then 0; io_start in HOLD with ready=0 -> io_overrun=1, frame unchanged.
REQ-033 Macro defined; frames 10'h100, 10'h2CB, 10'h050 -> io_maxResult 10'h100, 10'h2CB, 10'h2CB; macro undefined -> io_maxResult=0 throughout.
REQ-034 Reset pulsed low mid-COLLECT after 6 digits, no clock edge -> all outputs 0 immediately; next full frame collects correctly.
